// File: rtl/key_debounce_repeat.sv
// Push-button front-end: 2-flop synchroniser, stability-counter debounce and
// registered press / release / auto-repeat strobe pulses, one lane per key.
module key_debounce_repeat #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 50_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [N_KEYS-1:0] KEY_SW,
  output logic [N_KEYS-1:0] KEY_LEVEL,
  output logic [N_KEYS-1:0] PRESS,
  output logic [N_KEYS-1:0] RELEASE,
  output logic [N_KEYS-1:0] STROBE
);

  localparam int CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0] CNT_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] DELAY_LAST  = TW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);
  localparam bit            REPEAT_EN   = (REPEAT_DELAY != 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_t;

  logic [N_KEYS-1:0] sync1_r;
  logic [N_KEYS-1:0] sync2_r;
  logic [N_KEYS-1:0] key_s;
  logic [N_KEYS-1:0] accept_s;
  logic [N_KEYS-1:0] rise_s;
  logic [N_KEYS-1:0] fall_s;
  logic [N_KEYS-1:0] level_r;
  logic [N_KEYS-1:0] press_r;
  logic [N_KEYS-1:0] release_r;
  logic [N_KEYS-1:0] strobe_r;
  logic [CW-1:0]     cnt_r   [N_KEYS];
  logic [TW-1:0]     timer_r [N_KEYS];
  rep_state_t        state_r [N_KEYS];

  assign KEY_LEVEL = level_r;
  assign PRESS     = press_r;
  assign RELEASE   = release_r;
  assign STROBE    = strobe_r;

  // Synchroniser presets to released, so a key held across reset must debounce again.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync1_r <= {N_KEYS{1'b1}};
      sync2_r <= {N_KEYS{1'b1}};
    end else begin
      sync1_r <= KEY_SW;
      sync2_r <= sync1_r;
    end
  end

  // A differing level is accepted once it has been seen for DEBOUNCE_CYCLES edges.
  always_comb begin
    key_s    = ~sync2_r;
    accept_s = {N_KEYS{1'b0}};
    for (int k = 0; k < N_KEYS; k++) begin
      accept_s[k] = (key_s[k] != level_r[k]) && (cnt_r[k] == CNT_LAST);
    end
    rise_s = accept_s & key_s;
    fall_s = accept_s & ~key_s;
  end

  // Stability counters, debounced level and the press/release edge pulses.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int k = 0; k < N_KEYS; k++) begin
        cnt_r[k] <= {CW{1'b0}};
      end
      level_r   <= {N_KEYS{1'b0}};
      press_r   <= {N_KEYS{1'b0}};
      release_r <= {N_KEYS{1'b0}};
    end else begin
      for (int k = 0; k < N_KEYS; k++) begin
        if ((key_s[k] == level_r[k]) || accept_s[k]) begin
          cnt_r[k] <= {CW{1'b0}};
        end else begin
          cnt_r[k] <= cnt_r[k] + CW'(1'b1);
        end
      end
      level_r   <= level_r ^ accept_s;
      press_r   <= rise_s;
      release_r <= fall_s;
    end
  end

  // Repeat FSM per key; a falling level always wins over a due repeat strobe.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int k = 0; k < N_KEYS; k++) begin
        state_r[k] <= ST_IDLE;
        timer_r[k] <= {TW{1'b0}};
      end
      strobe_r <= {N_KEYS{1'b0}};
    end else begin
      strobe_r <= {N_KEYS{1'b0}};
      for (int k = 0; k < N_KEYS; k++) begin
        case (state_r[k])
          ST_IDLE: begin
            timer_r[k] <= {TW{1'b0}};
            if (rise_s[k]) begin
              state_r[k]  <= ST_HOLD;
              strobe_r[k] <= 1'b1;
            end else begin
              state_r[k] <= ST_IDLE;
            end
          end
          ST_HOLD: begin
            if (fall_s[k]) begin
              state_r[k] <= ST_IDLE;
              timer_r[k] <= {TW{1'b0}};
            end else if (REPEAT_EN) begin
              if (timer_r[k] == DELAY_LAST) begin
                state_r[k]  <= ST_REPEAT;
                timer_r[k]  <= {TW{1'b0}};
                strobe_r[k] <= 1'b1;
              end else begin
                timer_r[k] <= timer_r[k] + TW'(1'b1);
              end
            end else begin
              timer_r[k] <= {TW{1'b0}};
            end
          end
          ST_REPEAT: begin
            if (fall_s[k]) begin
              state_r[k] <= ST_IDLE;
              timer_r[k] <= {TW{1'b0}};
            end else if (timer_r[k] == PERIOD_LAST) begin
              timer_r[k]  <= {TW{1'b0}};
              strobe_r[k] <= 1'b1;
            end else begin
              timer_r[k] <= timer_r[k] + TW'(1'b1);
            end
          end
          default: begin
            state_r[k] <= ST_IDLE;
            timer_r[k] <= {TW{1'b0}};
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_debounce_repeat.sv
// Directed bench for key_debounce_repeat with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=8; expected per-cycle outputs are written out by hand in each task.
module tb_key_debounce_repeat;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] KEY_SW;
  logic [3:0] KEY_LEVEL;
  logic [3:0] PRESS;
  logic [3:0] RELEASE;
  logic [3:0] STROBE;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  key_debounce_repeat #(
    .N_KEYS(4),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(20),
    .REPEAT_PERIOD(8)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .KEY_SW(KEY_SW),
    .KEY_LEVEL(KEY_LEVEL),
    .PRESS(PRESS),
    .RELEASE(RELEASE),
    .STROBE(STROBE)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET  = 1'b0;
    KEY_SW = 4'hF;
    repeat (3) @(posedge CLK);
    #1;
    n_cmp++;
    if ({KEY_LEVEL, PRESS, RELEASE, STROBE} !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_hold got lvl/prs/rel/stb=%b_%b_%b_%b want all zero",
               KEY_LEVEL, PRESS, RELEASE, STROBE);
    end
    RESET = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      n_cmp++;
      if ({KEY_LEVEL, PRESS, RELEASE, STROBE} !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_idle c=%0d got lvl/prs/rel/stb=%b_%b_%b_%b want all zero",
                 c, KEY_LEVEL, PRESS, RELEASE, STROBE);
      end
    end
  endtask

  // Clean press of key 0, released after edge 8.
  task automatic test_single_press();
    logic [3:0] l, p, r, s;
    tick();
    KEY_SW = 4'b1110;
    for (int c = 1; c <= 16; c++) begin
      tick();
      l = {3'b000, (c >= 6 && c < 14)};
      p = {3'b000, (c == 6)};
      r = {3'b000, (c == 14)};
      s = {3'b000, (c == 6)};
      n_cmp++;
      if ({KEY_LEVEL, PRESS, RELEASE, STROBE} !== {l, p, r, s}) begin
        n_fail++;
        $display("FAIL single_press c=%0d got lvl/prs/rel/stb=%b_%b_%b_%b want %b_%b_%b_%b",
                 c, KEY_LEVEL, PRESS, RELEASE, STROBE, l, p, r, s);
      end
      if (c == 8) KEY_SW = 4'hF;
    end
  endtask

  // Key 0 bounces every 2 cycles until edge 12, then stays low.
  task automatic test_bounce();
    logic [3:0] l, p, r, s;
    tick();
    KEY_SW = 4'b1110;
    for (int c = 1; c <= 27; c++) begin
      tick();
      l = {3'b000, (c >= 18 && c < 26)};
      p = {3'b000, (c == 18)};
      r = {3'b000, (c == 26)};
      s = {3'b000, (c == 18)};
      n_cmp++;
      if ({KEY_LEVEL, PRESS, RELEASE, STROBE} !== {l, p, r, s}) begin
        n_fail++;
        $display("FAIL bounce c=%0d got lvl/prs/rel/stb=%b_%b_%b_%b want %b_%b_%b_%b",
                 c, KEY_LEVEL, PRESS, RELEASE, STROBE, l, p, r, s);
      end
      if (c <= 12 && (c % 2) == 0) KEY_SW[0] = (((c / 2) % 2) != 0);
      if (c == 20) KEY_SW = 4'hF;
    end
  endtask

  // Long hold: strobes at 6, 26, 34, 42, 50, 58; the repeat due at 66 is pre-empted by release.
  task automatic test_repeat();
    logic [3:0] l, p, r, s;
    tick();
    KEY_SW = 4'b1110;
    for (int c = 1; c <= 67; c++) begin
      tick();
      l = {3'b000, (c >= 6 && c < 66)};
      p = {3'b000, (c == 6)};
      r = {3'b000, (c == 66)};
      s = {3'b000, (c == 6) || (c >= 26 && c < 66 && ((c - 26) % 8) == 0)};
      n_cmp++;
      if ({KEY_LEVEL, PRESS, RELEASE, STROBE} !== {l, p, r, s}) begin
        n_fail++;
        $display("FAIL repeat c=%0d got lvl/prs/rel/stb=%b_%b_%b_%b want %b_%b_%b_%b",
                 c, KEY_LEVEL, PRESS, RELEASE, STROBE, l, p, r, s);
      end
      if (c == 60) KEY_SW = 4'hF;
    end
  endtask

  // Release during HOLD gives no repeat; a re-press restarts the full 20-cycle delay.
  task automatic test_release_in_hold();
    logic [3:0] l, p, r, s;
    tick();
    KEY_SW = 4'b1110;
    for (int c = 1; c <= 28; c++) begin
      tick();
      l = {3'b000, (c >= 6 && c < 22)};
      p = {3'b000, (c == 6)};
      r = {3'b000, (c == 22)};
      s = {3'b000, (c == 6)};
      n_cmp++;
      if ({KEY_LEVEL, PRESS, RELEASE, STROBE} !== {l, p, r, s}) begin
        n_fail++;
        $display("FAIL hold_release c=%0d got lvl/prs/rel/stb=%b_%b_%b_%b want %b_%b_%b_%b",
                 c, KEY_LEVEL, PRESS, RELEASE, STROBE, l, p, r, s);
      end
      if (c == 16) KEY_SW = 4'hF;
    end
    tick();
    KEY_SW = 4'b1110;
    for (int c = 1; c <= 34; c++) begin
      tick();
      l = {3'b000, (c >= 6 && c < 33)};
      p = {3'b000, (c == 6)};
      r = {3'b000, (c == 33)};
      s = {3'b000, (c == 6) || (c == 26)};
      n_cmp++;
      if ({KEY_LEVEL, PRESS, RELEASE, STROBE} !== {l, p, r, s}) begin
        n_fail++;
        $display("FAIL repress c=%0d got lvl/prs/rel/stb=%b_%b_%b_%b want %b_%b_%b_%b",
                 c, KEY_LEVEL, PRESS, RELEASE, STROBE, l, p, r, s);
      end
      if (c == 27) KEY_SW = 4'hF;
    end
  endtask

  // Keys 3 and 0 pressed on the same edge behave identically and in lock-step.
  task automatic test_two_keys();
    logic [3:0] l, p, r, s;
    tick();
    KEY_SW = 4'b0110;
    for (int c = 1; c <= 44; c++) begin
      tick();
      l = (c >= 6 && c < 42) ? 4'b1001 : 4'b0000;
      p = (c == 6) ? 4'b1001 : 4'b0000;
      r = (c == 42) ? 4'b1001 : 4'b0000;
      s = (c == 6 || c == 26 || c == 34) ? 4'b1001 : 4'b0000;
      n_cmp++;
      if ({KEY_LEVEL, PRESS, RELEASE, STROBE} !== {l, p, r, s}) begin
        n_fail++;
        $display("FAIL two_keys c=%0d got lvl/prs/rel/stb=%b_%b_%b_%b want %b_%b_%b_%b",
                 c, KEY_LEVEL, PRESS, RELEASE, STROBE, l, p, r, s);
      end
      if (c == 36) KEY_SW = 4'hF;
    end
  endtask

  // Reset while key 0 is repeating; held key re-debounces and repeat restarts from HOLD.
  task automatic test_reset_mid_repeat();
    logic [3:0] l, p, r, s;
    tick();
    KEY_SW = 4'b1110;
    for (int c = 1; c <= 30; c++) begin
      tick();
      l = {3'b000, (c >= 6)};
      p = {3'b000, (c == 6)};
      r = 4'b0000;
      s = {3'b000, (c == 6) || (c == 26)};
      n_cmp++;
      if ({KEY_LEVEL, PRESS, RELEASE, STROBE} !== {l, p, r, s}) begin
        n_fail++;
        $display("FAIL pre_reset c=%0d got lvl/prs/rel/stb=%b_%b_%b_%b want %b_%b_%b_%b",
                 c, KEY_LEVEL, PRESS, RELEASE, STROBE, l, p, r, s);
      end
    end
    RESET = 1'b0;
    #1;
    n_cmp++;
    if ({KEY_LEVEL, PRESS, RELEASE, STROBE} !== 16'h0000) begin
      n_fail++;
      $display("FAIL async_reset got lvl/prs/rel/stb=%b_%b_%b_%b want all zero",
               KEY_LEVEL, PRESS, RELEASE, STROBE);
    end
    tick();
    n_cmp++;
    if ({KEY_LEVEL, PRESS, RELEASE, STROBE} !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_edge got lvl/prs/rel/stb=%b_%b_%b_%b want all zero",
               KEY_LEVEL, PRESS, RELEASE, STROBE);
    end
    RESET = 1'b1;
    for (int c = 1; c <= 34; c++) begin
      tick();
      l = {3'b000, (c >= 6 && c < 33)};
      p = {3'b000, (c == 6)};
      r = {3'b000, (c == 33)};
      s = {3'b000, (c == 6) || (c == 26)};
      n_cmp++;
      if ({KEY_LEVEL, PRESS, RELEASE, STROBE} !== {l, p, r, s}) begin
        n_fail++;
        $display("FAIL post_reset c=%0d got lvl/prs/rel/stb=%b_%b_%b_%b want %b_%b_%b_%b",
                 c, KEY_LEVEL, PRESS, RELEASE, STROBE, l, p, r, s);
      end
      if (c == 27) KEY_SW = 4'hF;
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_repeat();
    test_release_in_hold();
    test_two_keys();
    test_reset_mid_repeat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
